// File: rtl/bidir_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bidir_bus_ctrl_pkg
// Brief    : Shared types and helpers for the bidirectional bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package bidir_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    // Width of the shared duration counter: must hold the longest phase
    // (TURN, DRIVE hold, or the 3-cycle synchronised SAMPLE).
    function automatic int cnt_width(input int turn_cycles, input int hold_cycles);
        int m;
        m = (turn_cycles > hold_cycles) ? turn_cycles : hold_cycles;
        if (m < 3) m = 3;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bidir_bus_ctrl_pad_sync.sv
`default_nettype none
// ============================================================================
// Module   : pad_sync
// Brief    : WIDTH-bit two-flop synchroniser for the pad input bus.
//            Only instantiated when BIDIR_BUS_CTRL_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pad_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    // Next values of the two synchroniser stages.
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    // Synchroniser stages, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule
`default_nettype wire

// File: rtl/bidir_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bidir_bus_ctrl
// Brief    : Half-duplex controller for a tristate pad. Turns single-beat
//            read/write commands into bus cycles with enforced turnaround.
//            Optional macro BIDIR_BUS_CTRL_SYNC_EN adds a 2-flop synchroniser
//            on pad_o and stretches SAMPLE to 3 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bidir_bus_ctrl
    import bidir_bus_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             busy,
    output logic             pad_t,
    output logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] pad_o
);

`ifdef BIDIR_BUS_CTRL_SYNC_EN
    localparam int SAMPLE_CYCLES = 3;
`else
    localparam int SAMPLE_CYCLES = 1;
`endif
    localparam int CNT_W = cnt_width(TURN_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               pad_t_q, pad_t_d;
    logic [WIDTH-1:0]   pad_i_q, pad_i_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [WIDTH-1:0]   sample_src;

`ifdef BIDIR_BUS_CTRL_SYNC_EN
    pad_sync #(.WIDTH(WIDTH)) u_pad_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_o),
        .q   (sample_src)
    );
`else
    assign sample_src = pad_o;
`endif

    // Next-state, counter and registered-output logic for the bus FSM.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        pad_t_d     = pad_t_q;
        pad_i_d     = pad_i_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    wdata_d = cmd_wdata;
                    if (cmd_write != dir_q) begin
                        // Direction change: release the bus first.
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                        pad_t_d = 1'b0;
                    end else if (cmd_write) begin
                        state_d = ST_DRIVE;
                        cnt_d   = HOLD_LOAD;
                        pad_t_d = 1'b1;
                        pad_i_d = cmd_wdata;
                    end else begin
                        state_d = ST_SAMPLE;
                        cnt_d   = SAMPLE_LOAD;
                        pad_t_d = 1'b0;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (write_q) begin
                    state_d = ST_DRIVE;
                    cnt_d   = HOLD_LOAD;
                    pad_t_d = 1'b1;
                    pad_i_d = wdata_q;
                end else begin
                    state_d = ST_SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end
            end
            ST_DRIVE: begin
                dir_d = 1'b1;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_IDLE;
            end
            ST_SAMPLE: begin
                dir_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = sample_src;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset releases the bus and drops any read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            pad_t_q     <= 1'b0;
            pad_i_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            pad_t_q     <= pad_t_d;
            pad_i_q     <= pad_i_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign pad_t     = pad_t_q;
    assign pad_i     = pad_i_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bidir_bus_ctrl
// Brief    : Self-checking bench for bidir_bus_ctrl (vector table plus
//            read-data scoreboard and hand-written reset sequence).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bidir_bus_ctrl;

    localparam int TC = 2;
    localparam int HC = 1;
`ifdef BIDIR_BUS_CTRL_SYNC_EN
    localparam int RX = 2;
`else
    localparam int RX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       pad_t;
    logic [7:0] pad_i;
    logic [7:0] pad_o = 8'h00;

    int tests  = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic [7:0] p;
        int         lat;
        int         low;
    } vec_t;
    vec_t vecs[10];

    bidir_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(TC), .HOLD_CYCLES(HC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .pad_t     (pad_t),
        .pad_i     (pad_i),
        .pad_o     (pad_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every response pops the oldest expected read value.
    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 1, 0);
            end else begin
                chk("rsp_rdata", int'(rsp_rdata), int'(exp_q.pop_front()));
            end
        end
    end

    // Issue one command (called at posedge+1 with DUT idle) and follow it
    // until cmd_ready returns, checking latency and pad behaviour.
    task automatic issue(input vec_t v, input int idx);
        int cyc;
        int low;
        chk($sformatf("v%0d_ready_at_issue", idx), int'(cmd_ready), 1);
        pad_o     = v.p;
        cmd_valid = 1'b1;
        cmd_write = v.w;
        cmd_wdata = v.d;
        if (!v.w) exp_q.push_back(v.p);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_wdata = ~v.d;
        cyc = 1;
        low = 0;
        while (!cmd_ready && cyc < 50) begin
            if (!pad_t) low++;
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("v%0d_latency", idx), cyc, v.lat);
        chk($sformatf("v%0d_pad_t_low_cycles", idx), low, v.low);
        if (v.w) begin
            chk($sformatf("v%0d_parked_pad_t", idx), int'(pad_t), 1);
            chk($sformatf("v%0d_pad_i", idx), int'(pad_i), int'(v.d));
        end else begin
            chk($sformatf("v%0d_rsp_valid_at_done", idx), int'(rsp_valid), 1);
            chk($sformatf("v%0d_pad_t_released", idx), int'(pad_t), 0);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic [7:0] p,
                                input logic turn);
        vec_t v;
        v.w = w; v.d = d; v.p = p;
        if (w) begin
            v.lat = turn ? (TC + HC + 1) : (HC + 1);
            v.low = turn ? TC : 0;
        end else begin
            v.lat = turn ? (TC + 2 + RX) : (2 + RX);
            v.low = v.lat - 1;
        end
        return v;
    endfunction

    initial begin
        vecs[0] = mk(1'b1, 8'hA5, 8'h00, 1'b1);
        vecs[1] = mk(1'b1, 8'h3C, 8'h00, 1'b0);
        vecs[2] = mk(1'b1, 8'hC3, 8'h00, 1'b0);
        vecs[3] = mk(1'b0, 8'h00, 8'h5A, 1'b1);
        vecs[4] = mk(1'b0, 8'h00, 8'h11, 1'b0);
        vecs[5] = mk(1'b0, 8'h00, 8'h22, 1'b0);
        vecs[6] = mk(1'b1, 8'h0F, 8'h00, 1'b1);
        vecs[7] = mk(1'b0, 8'h00, 8'hE7, 1'b1);
        vecs[8] = mk(1'b1, 8'h81, 8'h00, 1'b1);
        vecs[9] = mk(1'b1, 8'h7E, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and quiet idle period.
        chk("rst_pad_t", int'(pad_t), 0);
        chk("rst_pad_i", int'(pad_i), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_outputs", int'({pad_t, pad_i, rsp_valid, cmd_ready, busy}),
                int'({1'b0, 8'h00, 1'b0, 1'b1, 1'b0}));
        end

        // Table of back-to-back commands.
        for (int i = 0; i < 10; i++) issue(vecs[i], i);

        // Reset during the TURN of a read that follows a write.
        pad_o     = 8'h99;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("turn_pad_t_low", int'(pad_t), 0);
        chk("turn_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_idle", int'(cmd_ready), 1);
        chk("midrst_pad_t", int'(pad_t), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        repeat (6) @(posedge clk);
        #1;
        issue(mk(1'b1, 8'h5C, 8'h00, 1'b1), 10);

        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
